// File: rtl/hazard_control_unit.sv
// Producer-side hazard control for the 5-stage RV32 pipeline: shadows EX/MEM
// destinations, decides stalls/flushes/freezes and counts stall cycles.

module hcu_src_chk #(
  parameter int REG_AW = 5
) (
  input  logic              use_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic              ex_vld_in,
  input  logic [REG_AW-1:0] ex_rd_in,
  input  logic              ex_ld_in,
  input  logic              mem_vld_in,
  input  logic [REG_AW-1:0] mem_rd_in,
  input  logic              mem_ld_in,
  output logic              load_use_out,
  output logic              br_hit_out
);
  logic hit_ex, hit_mem;

  assign hit_ex       = use_in & ex_vld_in  & (ex_rd_in  == rs_in);
  assign hit_mem      = use_in & mem_vld_in & (mem_rd_in == rs_in);
  assign load_use_out = hit_ex & ex_ld_in;
  // A decode-resolved branch can only take ALU results from MEM, never loads.
  assign br_hit_out   = hit_ex | (hit_mem & mem_ld_in);
endmodule

module hazard_control_unit #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_in,
  input  logic [REG_AW-1:0] id_rs1_in,
  input  logic [REG_AW-1:0] id_rs2_in,
  input  logic              id_uses_rs1_in,
  input  logic              id_uses_rs2_in,
  input  logic [REG_AW-1:0] id_rd_in,
  input  logic              id_regwrite_in,
  input  logic              id_memread_in,
  input  logic              id_branch_in,
  input  logic              ex_redirect_in,
  input  logic              mem_wait_in,
  output logic              pc_write_out,
  output logic              ifid_write_out,
  output logic              idex_bubble_out,
  output logic              ifid_flush_out,
  output logic [CNT_W-1:0]  stall_cnt_out
);
  localparam int NUM_SRC = 2;

  logic                           ex_vld_q, ex_vld_d;
  logic [REG_AW-1:0]              ex_rd_q,  ex_rd_d;
  logic                           ex_ld_q,  ex_ld_d;
  logic                           mem_vld_q, mem_vld_d;
  logic [REG_AW-1:0]              mem_rd_q,  mem_rd_d;
  logic                           mem_ld_q,  mem_ld_d;
  logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0][REG_AW-1:0] src_rs;
  logic [NUM_SRC-1:0]             src_use;
  logic [NUM_SRC-1:0]             src_lu;
  logic [NUM_SRC-1:0]             src_br;
  logic                           load_use, br_hz, stall, issue;

  assign src_rs[0]  = id_rs1_in;
  assign src_rs[1]  = id_rs2_in;
  assign src_use[0] = id_valid_in & id_uses_rs1_in & (id_rs1_in != '0);
  assign src_use[1] = id_valid_in & id_uses_rs2_in & (id_rs2_in != '0);

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hcu_src_chk #(.REG_AW(REG_AW)) u_chk (
      .use_in       (src_use[s]),
      .rs_in        (src_rs[s]),
      .ex_vld_in    (ex_vld_q),
      .ex_rd_in     (ex_rd_q),
      .ex_ld_in     (ex_ld_q),
      .mem_vld_in   (mem_vld_q),
      .mem_rd_in    (mem_rd_q),
      .mem_ld_in    (mem_ld_q),
      .load_use_out (src_lu[s]),
      .br_hit_out   (src_br[s])
    );
  end

  assign load_use = |src_lu;
  assign br_hz    = id_branch_in & (|src_br);
  assign stall    = (load_use | br_hz) & ~ex_redirect_in;
  assign issue    = id_valid_in & id_regwrite_in & (id_rd_in != '0) & ~stall & ~ex_redirect_in;

  always_comb begin
    pc_write_out    = 1'b1;
    ifid_write_out  = 1'b1;
    idex_bubble_out = 1'b0;
    ifid_flush_out  = 1'b0;
    if (rst) begin
      pc_write_out    = 1'b0;
      ifid_write_out  = 1'b0;
      idex_bubble_out = 1'b1;
      ifid_flush_out  = 1'b1;
    end else if (mem_wait_in) begin
      pc_write_out    = 1'b0;
      ifid_write_out  = 1'b0;
    end else if (ex_redirect_in) begin
      idex_bubble_out = 1'b1;
      ifid_flush_out  = 1'b1;
    end else if (stall) begin
      pc_write_out    = 1'b0;
      ifid_write_out  = 1'b0;
      idex_bubble_out = 1'b1;
    end
  end

  // Whole tracker holds during a memory freeze so a pending redirect replays.
  always_comb begin
    ex_vld_d    = ex_vld_q;
    ex_rd_d     = ex_rd_q;
    ex_ld_d     = ex_ld_q;
    mem_vld_d   = mem_vld_q;
    mem_rd_d    = mem_rd_q;
    mem_ld_d    = mem_ld_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_wait_in) begin
      mem_vld_d = ex_vld_q;
      mem_rd_d  = ex_rd_q;
      mem_ld_d  = ex_ld_q;
      if (issue) begin
        ex_vld_d = 1'b1;
        ex_rd_d  = id_rd_in;
        ex_ld_d  = id_memread_in;
      end else begin
        ex_vld_d = 1'b0;
        ex_rd_d  = '0;
        ex_ld_d  = 1'b0;
      end
      if (stall && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_vld_q    <= 1'b0;
      ex_rd_q     <= '0;
      ex_ld_q     <= 1'b0;
      mem_vld_q   <= 1'b0;
      mem_rd_q    <= '0;
      mem_ld_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_vld_q    <= ex_vld_d;
      ex_rd_q     <= ex_rd_d;
      ex_ld_q     <= ex_ld_d;
      mem_vld_q   <= mem_vld_d;
      mem_rd_q    <= mem_rd_d;
      mem_ld_q    <= mem_ld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed vector bench for hazard_control_unit (4-bit counter to reach saturation).

module tb_hazard_control_unit;
  localparam int CNT_W  = 4;
  localparam int REG_AW = 5;

  localparam logic [3:0] NORM = 4'b1100; // {pc_write, ifid_write, bubble, flush}
  localparam logic [3:0] STL  = 4'b0010;
  localparam logic [3:0] RDR  = 4'b1111;
  localparam logic [3:0] FRZ  = 4'b0000;
  localparam logic [3:0] RST  = 4'b0011;

  typedef struct {
    logic              rst;
    logic              vld;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
    logic              br;
    logic              redir;
    logic              wt;
    logic [3:0]        exp_ctl;
    logic [CNT_W-1:0]  exp_cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid_in = 1'b0;
  logic [REG_AW-1:0] id_rs1_in = '0;
  logic [REG_AW-1:0] id_rs2_in = '0;
  logic              id_uses_rs1_in = 1'b0;
  logic              id_uses_rs2_in = 1'b0;
  logic [REG_AW-1:0] id_rd_in = '0;
  logic              id_regwrite_in = 1'b0;
  logic              id_memread_in = 1'b0;
  logic              id_branch_in = 1'b0;
  logic              ex_redirect_in = 1'b0;
  logic              mem_wait_in = 1'b0;
  logic              pc_write_out, ifid_write_out, idex_bubble_out, ifid_flush_out;
  logic [CNT_W-1:0]  stall_cnt_out;

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  hazard_control_unit #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid_in     (id_valid_in),
    .id_rs1_in       (id_rs1_in),
    .id_rs2_in       (id_rs2_in),
    .id_uses_rs1_in  (id_uses_rs1_in),
    .id_uses_rs2_in  (id_uses_rs2_in),
    .id_rd_in        (id_rd_in),
    .id_regwrite_in  (id_regwrite_in),
    .id_memread_in   (id_memread_in),
    .id_branch_in    (id_branch_in),
    .ex_redirect_in  (ex_redirect_in),
    .mem_wait_in     (mem_wait_in),
    .pc_write_out    (pc_write_out),
    .ifid_write_out  (ifid_write_out),
    .idex_bubble_out (idex_bubble_out),
    .ifid_flush_out  (ifid_flush_out),
    .stall_cnt_out   (stall_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic add_v(input logic r, input logic vl, input int rs1, input int rs2,
                       input logic u1, input logic u2, input int rd, input logic rw,
                       input logic mr, input logic br, input logic redir, input logic wt,
                       input logic [3:0] ctl, input int cnt);
    vec_t v;
    v.rst = r; v.vld = vl; v.rs1 = REG_AW'(rs1); v.rs2 = REG_AW'(rs2);
    v.u1 = u1; v.u2 = u2; v.rd = REG_AW'(rd); v.rw = rw; v.mr = mr; v.br = br;
    v.redir = redir; v.wt = wt; v.exp_ctl = ctl; v.exp_cnt = CNT_W'(cnt);
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, check 1 time unit later, commit at the next rising edge.
  task automatic apply(input vec_t v, input string name);
    logic [3:0] ctl;
    @(negedge clk);
    rst = v.rst; id_valid_in = v.vld; id_rs1_in = v.rs1; id_rs2_in = v.rs2;
    id_uses_rs1_in = v.u1; id_uses_rs2_in = v.u2; id_rd_in = v.rd;
    id_regwrite_in = v.rw; id_memread_in = v.mr; id_branch_in = v.br;
    ex_redirect_in = v.redir; mem_wait_in = v.wt;
    #1;
    ctl = {pc_write_out, ifid_write_out, idex_bubble_out, ifid_flush_out};
    tests++;
    if (ctl !== v.exp_ctl) begin
      fails++;
      $display("FAIL %s ctl: got %b expected %b", name, ctl, v.exp_ctl);
    end
    tests++;
    if (stall_cnt_out !== v.exp_cnt) begin
      fails++;
      $display("FAIL %s cnt: got %0d expected %0d", name, stall_cnt_out, v.exp_cnt);
    end
  endtask

  initial begin
    vec_t v;
    //     rst vl rs1 rs2 u1 u2 rd rw mr br rdr wt  ctl  cnt
    add_v(1, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, RST,  0); // 0 reset
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0); // 1 release
    add_v(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, NORM, 0); // 2 lw x5
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, STL,  0); // 3 add x6,x5,x7
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, NORM, 1); // 4 add proceeds
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1); // 5
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1); // 6
    add_v(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, NORM, 1); // 7 lw x5
    add_v(0, 1, 5, 0, 1, 1, 0, 0, 0, 1, 0, 0, STL,  1); // 8 beq x5,x0 (EX load)
    add_v(0, 1, 5, 0, 1, 1, 0, 0, 0, 1, 0, 0, STL,  2); // 9 beq (MEM load)
    add_v(0, 1, 5, 0, 1, 1, 0, 0, 0, 1, 0, 0, NORM, 3); // 10
    add_v(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, NORM, 3); // 11 add x3
    add_v(0, 1, 3, 4, 1, 1, 0, 0, 0, 1, 0, 0, STL,  3); // 12 beq x3,x4
    add_v(0, 1, 3, 4, 1, 1, 0, 0, 0, 1, 0, 0, NORM, 4); // 13 forward from MEM
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 4); // 14
    add_v(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, NORM, 4); // 15 addi x0
    add_v(0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, NORM, 4); // 16 beq x0,x0
    add_v(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, NORM, 4); // 17 lw x5
    add_v(0, 1, 5, 0, 1, 0, 9, 1, 1, 0, 1, 0, RDR,  4); // 18 lw x9,(x5) squashed
    add_v(0, 1, 9, 0, 1, 0,10, 1, 0, 1, 0, 0, NORM, 4); // 19 x9 not tracked
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 4); // 20
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 4); // 21
    add_v(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, NORM, 4); // 22 lw x5
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 1, FRZ,  4); // 23 freeze
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 1, 1, FRZ,  4); // 24 freeze beats redirect
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 1, FRZ,  4); // 25 freeze
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, STL,  4); // 26 stall survives freeze
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, NORM, 5); // 27
    add_v(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, NORM, 5); // 28 lw x5
    add_v(1, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, RST,  0); // 29 reset mid-stall
    add_v(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, NORM, 0); // 30 no residual stall
    add_v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0); // 31

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Counter saturation: repeated load-use pairs, 17 stalls into a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      int c;
      c = (i > 15) ? 15 : i;
      v = '{rst:0, vld:1, rs1:1, rs2:0, u1:1, u2:0, rd:5, rw:1, mr:1, br:0,
            redir:0, wt:0, exp_ctl:NORM, exp_cnt:CNT_W'(c)};
      apply(v, $sformatf("sat_lw%0d", i));
      v = '{rst:0, vld:1, rs1:5, rs2:7, u1:1, u2:1, rd:6, rw:1, mr:0, br:0,
            redir:0, wt:0, exp_ctl:STL, exp_cnt:CNT_W'(c)};
      apply(v, $sformatf("sat_add%0d", i));
    end
    v = '{rst:0, vld:0, rs1:0, rs2:0, u1:0, u2:0, rd:0, rw:0, mr:0, br:0,
          redir:0, wt:0, exp_ctl:NORM, exp_cnt:CNT_W'(15)};
    apply(v, "sat_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
